// File: rtl/frag_fb_writer.sv
// rtl/frag_fb_writer.sv - fragment-to-framebuffer pixel writer with bounded outstanding writes
package frag_fb_pkg;
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } fragment_t;
endpackage

module frag_fb_writer
  import frag_fb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int BPP_SHIFT       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] fb_base,
  input  logic [15:0] fb_width,
  input  logic [15:0] fb_height,
  input  logic [31:0] color,
  input  logic        frag_val,
  input  fragment_t   frag,
  output logic        pop_frag,
  input  logic        gen_done,
  output logic        mem_req_val,
  input  logic        mem_req_rdy,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  input  logic        mem_rsp_val,
  output logic [31:0] frag_count,
  output logic [31:0] clip_count,
  output logic        done
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {IDLE, ACCEPT, ADDR, REQ, DRAIN} state_t;

  state_t      state;
  logic [31:0] base_r;
  logic [15:0] width_r;
  logic [15:0] height_r;
  logic [31:0] color_r;
  logic [31:0] x_r;
  logic [31:0] y_r;
  logic [OW-1:0] outstanding;
  logic        sticky;
  logic        hs;
  logic        ack;
  logic        clip;
  logic [31:0] pix_idx;
  logic        unused_frag;

  // Barycentric weights are not needed for a flat-colour fill.
  assign unused_frag = ^{frag.w0, frag.w1, frag.w2};

  assign pop_frag     = (state == ACCEPT) && frag_val && (outstanding < OW'(MAX_OUTSTANDING));
  assign hs           = (state == REQ) && mem_req_val && mem_req_rdy;
  assign ack          = mem_rsp_val && (outstanding != '0);
  assign clip         = (x_r >= {16'd0, width_r}) || (y_r >= {16'd0, height_r});
  assign pix_idx      = 32'(y_r[15:0]) * 32'(width_r) + 32'(x_r[15:0]);
  assign mem_req_data = color_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      base_r       <= '0;
      width_r      <= '0;
      height_r     <= '0;
      color_r      <= '0;
      x_r          <= '0;
      y_r          <= '0;
      outstanding  <= '0;
      sticky       <= 1'b0;
      frag_count   <= '0;
      clip_count   <= '0;
      mem_req_val  <= 1'b0;
      mem_req_addr <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;

      if (hs && !ack)
        outstanding <= outstanding + OW'(1);
      else if (!hs && ack)
        outstanding <= outstanding - OW'(1);

      if (state != IDLE && gen_done)
        sticky <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            base_r     <= fb_base;
            width_r    <= fb_width;
            height_r   <= fb_height;
            color_r    <= color;
            frag_count <= '0;
            clip_count <= '0;
            sticky     <= 1'b0;
            state      <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (pop_frag) begin
            x_r   <= frag.x;
            y_r   <= frag.y;
            state <= ADDR;
          end else if (sticky && !frag_val) begin
            state <= DRAIN;
          end
        end
        ADDR: begin
          if (clip) begin
            if (clip_count != '1)
              clip_count <= clip_count + 32'd1;
            state <= ACCEPT;
          end else begin
            mem_req_addr <= base_r + (pix_idx << BPP_SHIFT);
            mem_req_val  <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (mem_req_rdy) begin
            mem_req_val <= 1'b0;
            if (frag_count != '1)
              frag_count <= frag_count + 32'd1;
            state <= ACCEPT;
          end
        end
        DRAIN: begin
          if (frag_val) begin
            state <= ACCEPT;
          end else if (outstanding == '0 || (outstanding == OW'(1) && mem_rsp_val)) begin
            // Looking at this cycle's ack lets done follow the final ack by one cycle.
            done   <= 1'b1;
            sticky <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frag_fb_writer.sv
// tb/tb_frag_fb_writer.sv - directed self-checking bench for frag_fb_writer
module tb_frag_fb_writer;
  import frag_fb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] fb_base;
  logic [15:0] fb_width;
  logic [15:0] fb_height;
  logic [31:0] color;
  logic        frag_val;
  fragment_t   frag;
  logic        pop_frag;
  logic        gen_done;
  logic        mem_req_val;
  logic        mem_req_rdy;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_rsp_val;
  logic [31:0] frag_count;
  logic [31:0] clip_count;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  frag_fb_writer #(.MAX_OUTSTANDING(4), .BPP_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .fb_base(fb_base), .fb_width(fb_width),
    .fb_height(fb_height), .color(color), .frag_val(frag_val), .frag(frag),
    .pop_frag(pop_frag), .gen_done(gen_done), .mem_req_val(mem_req_val),
    .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_rsp_val(mem_rsp_val), .frag_count(frag_count), .clip_count(clip_count), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frag(input logic [31:0] x, input logic [31:0] y);
    frag.x  = x;
    frag.y  = y;
    frag.w0 = 32'hAAAA_0000 ^ x;
    frag.w1 = 32'h5555_0000 ^ y;
    frag.w2 = 32'h0F0F_0F0F;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] w, input logic [15:0] h,
                          input logic [31:0] c);
    fb_base = b; fb_width = w; fb_height = h; color = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    fb_base = 32'hFFFF_0000; fb_width = 16'd1; fb_height = 16'd1; color = 32'h0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fb_base = '0; fb_width = '0; fb_height = '0; color = '0;
    frag_val = 1'b0; gen_done = 1'b0; mem_req_rdy = 1'b0; mem_rsp_val = 1'b0;
    set_frag(0, 0);
    tick(); tick();
    rst = 1'b0;

    check("rst_req_val", 32'(mem_req_val), 0);
    check("rst_done", 32'(done), 0);
    check("rst_frag_count", frag_count, 0);
    check("rst_clip_count", clip_count, 0);
    frag_val = 1'b1; #1;
    check("idle_no_pop", 32'(pop_frag), 0);
    tick();
    frag_val = 1'b0;

    // basic write
    do_start(32'h1000, 16'd640, 16'd480, 32'hDEAD_BEEF);
    mem_req_rdy = 1'b1;
    set_frag(3, 2); frag_val = 1'b1; #1;
    check("pop_basic", 32'(pop_frag), 1);
    tick();
    frag_val = 1'b0; #1;
    check("pop_low_no_val", 32'(pop_frag), 0);
    tick();
    check("basic_req_val", 32'(mem_req_val), 1);
    check("basic_addr", mem_req_addr, 32'h240C);
    check("basic_data", mem_req_data, 32'hDEAD_BEEF);
    tick();
    check("basic_req_drop", 32'(mem_req_val), 0);
    check("basic_frag_count", frag_count, 1);
    mem_rsp_val = 1'b1; tick(); mem_rsp_val = 1'b0;

    // clipping on both axes
    set_frag(640, 0); frag_val = 1'b1; tick(); frag_val = 1'b0;
    tick();
    check("clipx_no_req", 32'(mem_req_val), 0);
    check("clipx_count", clip_count, 1);
    set_frag(0, 480); frag_val = 1'b1; tick(); frag_val = 1'b0;
    tick();
    check("clipy_no_req", 32'(mem_req_val), 0);
    check("clipy_count", clip_count, 2);
    check("clip_frag_count", frag_count, 1);

    // corner pixel under backpressure
    mem_req_rdy = 1'b0;
    set_frag(639, 479); frag_val = 1'b1; tick();
    set_frag(7, 7); tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_val", 32'(mem_req_val), 1);
      check("stall_addr", mem_req_addr, 32'h0012_CFFC);
      check("stall_data", mem_req_data, 32'hDEAD_BEEF);
      check("stall_no_pop", 32'(pop_frag), 0);
      tick();
    end
    mem_req_rdy = 1'b1; frag_val = 1'b0;
    tick();
    check("stall_release_val", 32'(mem_req_val), 0);
    check("stall_frag_count", frag_count, 2);
    mem_rsp_val = 1'b1; tick(); mem_rsp_val = 1'b0;

    // outstanding limit
    for (int i = 0; i < 4; i++) begin
      set_frag(32'(i), 0); frag_val = 1'b1; #1;
      check("limit_pop", 32'(pop_frag), 1);
      tick(); frag_val = 1'b0; tick(); tick();
    end
    check("limit_frag_count", frag_count, 6);
    set_frag(4, 0); frag_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("limit_block_pop", 32'(pop_frag), 0);
      check("limit_block_req", 32'(mem_req_val), 0);
      tick();
    end
    mem_rsp_val = 1'b1; tick(); mem_rsp_val = 1'b0; #1;
    check("limit_resume_pop", 32'(pop_frag), 1);
    tick(); frag_val = 1'b0; tick();
    check("limit_5th_val", 32'(mem_req_val), 1);
    check("limit_5th_addr", mem_req_addr, 32'h1010);
    tick();
    check("limit_frag_count7", frag_count, 7);

    // drain with two writes still unacknowledged
    mem_rsp_val = 1'b1; tick(); tick(); mem_rsp_val = 1'b0;
    gen_done = 1'b1; tick(); gen_done = 1'b0;
    tick();
    check("drain_done_low0", 32'(done), 0);
    tick();
    check("drain_done_low1", 32'(done), 0);
    mem_rsp_val = 1'b1; tick(); mem_rsp_val = 1'b0;
    check("drain_done_low2", 32'(done), 0);
    mem_rsp_val = 1'b1; tick(); mem_rsp_val = 1'b0;
    check("drain_done_pulse", 32'(done), 1);
    tick();
    check("drain_done_clear", 32'(done), 0);
    check("drain_keep_count", frag_count, 7);
    frag_val = 1'b1; #1;
    check("drain_idle_no_pop", 32'(pop_frag), 0);
    frag_val = 1'b0;

    // restart clears counters; start outside IDLE ignored
    do_start(32'h8000_0000, 16'd10, 16'd10, 32'h1234_5678);
    check("restart_frag_count", frag_count, 0);
    check("restart_clip_count", clip_count, 0);
    fb_base = 32'h5000; fb_width = 16'd100; color = 32'h0BAD_0BAD; start = 1'b1; tick(); start = 1'b0;
    set_frag(20, 0); frag_val = 1'b1; tick(); frag_val = 1'b0; tick();
    check("restart_clip", clip_count, 1);
    mem_req_rdy = 1'b0;
    set_frag(1, 1); frag_val = 1'b1; tick(); frag_val = 1'b0; tick();
    check("restart_addr", mem_req_addr, 32'h8000_002C);
    check("restart_data", mem_req_data, 32'h1234_5678);
    check("restart_val", 32'(mem_req_val), 1);

    // reset in the middle of a request
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_val", 32'(mem_req_val), 0);
    check("midrst_clip", clip_count, 0);
    check("midrst_frag", frag_count, 0);
    frag_val = 1'b1; #1;
    check("midrst_idle_no_pop", 32'(pop_frag), 0);
    frag_val = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frag_fb_writer.md
FRAG_FB_WRITER -- requirements
Module: frag_fb_writer

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, SHALL be the maximum number of unacknowledged memory writes.
REQ-002 Parameter BPP_SHIFT, default 2, SHALL be log2 of bytes per pixel.
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle pulse; latches config and clears counters.
REQ-006 fb_base  in  32  framebuffer byte base address, latched on start.
REQ-007 fb_width, fb_height  in  16 each  framebuffer dimensions in pixels, latched on start.
REQ-008 color  in  32  pixel write data, latched on start.
REQ-009 frag_val  in  1  upstream fragment FIFO head valid.
REQ-010 frag  in  fragment_t  fields x, y, w0, w1, w2, 32 bits each.
REQ-011 pop_frag  out  1  combinational; consumes the head fragment this cycle.
REQ-012 gen_done  in  1  one-cycle pulse from fragment_generator: no further fragments will be produced.
REQ-013 mem_req_val/mem_req_rdy  out/in  1  write request handshake.
REQ-014 mem_req_addr, mem_req_data  out  32 each  byte address and pixel data.
REQ-015 mem_rsp_val  in  1  one write acknowledge per cycle asserted.
REQ-016 frag_count, clip_count  out  32 each  fragments written, fragments discarded.
REQ-017 done  out  1  one-cycle pulse when all work has drained.

Function
REQ-018 States SHALL be IDLE, ACCEPT, ADDR, REQ, DRAIN.
REQ-019 IDLE: on start, latch config, zero both counters and the gen_done sticky flag, and go to ACCEPT; all other inputs are ignored.
REQ-020 pop_frag SHALL equal (state==ACCEPT && frag_val && outstanding<MAX_OUTSTANDING), and SHALL never assert while frag_val=0.
REQ-021 On pop, register frag.x and frag.y and go to ADDR; w0/w1/w2 are discarded.
REQ-022 ADDR: if x>=zero-extended fb_width or y>=zero-extended fb_height (32-bit unsigned compare), clip_count increments and the state returns to ACCEPT with no memory request.
REQ-023 ADDR otherwise: register addr = fb_base + ((y[15:0]*fb_width + x[15:0]) << BPP_SHIFT), computed mod 2^32, and go to REQ.
REQ-024 REQ: mem_req_val=1 with addr and data held stable until mem_req_rdy=1; on the handshake frag_count increments, outstanding increments, and the state returns to ACCEPT.
REQ-025 Throughput SHALL be one write per 3 cycles when mem_req_rdy is held high and acknowledgements keep pace.
REQ-026 outstanding SHALL decrement on mem_rsp_val, stay unchanged on a simultaneous handshake and acknowledge, and ignore mem_rsp_val when it is 0 (no underflow).
REQ-027 gen_done SHALL set a sticky flag in any non-IDLE state.
REQ-028 ACCEPT with sticky set and frag_val=0 SHALL go to DRAIN.
REQ-029 DRAIN: if frag_val rises, return to ACCEPT; when outstanding==0, pulse done for one cycle, clear the sticky flag, and go to IDLE.
REQ-030 Counters SHALL saturate at 2^32-1.
REQ-031 start outside IDLE SHALL be ignored.

Reset
REQ-032 On rst: state=IDLE, outstanding=0, sticky=0, frag_count=0, clip_count=0, mem_req_val=0, pop_frag=0, done=0, latched config=0; rst mid-request drops the request without acknowledgement.

Verification
REQ-033 fb_base=0x1000, width=640, height=480, frag x=3,y=2, rdy=1 -> one pop, mem_req_addr=0x1000+(1283<<2)=0x240C, data=color, frag_count=1.
REQ-034 frag x=640,y=0 -> no mem_req_val, clip_count=1; frag x=0,y=480 -> clip_count=2.
REQ-035 mem_req_rdy=0 for 5 cycles -> addr/data stable, mem_req_val high, no further pop; rdy=1 -> handshake in one cycle.
REQ-036 5 frags queued, no acknowledgements, MAX_OUTSTANDING=4 -> exactly 4 writes, pop_frag low; one mem_rsp_val -> 5th write issues.
REQ-037 gen_done with 2 writes unacknowledged -> DRAIN, done stays low; second ack -> done pulses exactly one cycle later, state IDLE.
REQ-038 rst asserted in REQ with rdy=0 -> next cycle mem_req_val=0, counters=0, state IDLE.
